// File: rtl/axi_mm_cache_slave.sv
// AXI4 memory-mapped slave: on-chip word memory behind a direct-mapped,
// write-through, no-write-allocate read cache. One transaction in flight.
module axi_mm_cache_slave #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int MEM_WORDS      = 1024,
  parameter int CACHE_LINES    = 16,
  parameter int MISS_LATENCY   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  input  logic                          M_AXI_AWVALID,
  output logic                          M_AXI_AWREADY,
  input  logic [AXI_ID_WIDTH-1:0]       M_AXI_AWID,
  input  logic [1:0]                    M_AXI_AWBURST,
  input  logic [2:0]                    M_AXI_AWSIZE,
  input  logic [7:0]                    M_AXI_AWLEN,
  input  logic [AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  input  logic [AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  input  logic                          M_AXI_WVALID,
  input  logic                          M_AXI_WLAST,
  output logic                          M_AXI_WREADY,
  output logic [1:0]                    M_AXI_BRESP,
  output logic                          M_AXI_BVALID,
  output logic [AXI_ID_WIDTH-1:0]       M_AXI_BID,
  input  logic                          M_AXI_BREADY,
  input  logic [AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  input  logic                          M_AXI_ARVALID,
  output logic                          M_AXI_ARREADY,
  input  logic [AXI_ID_WIDTH-1:0]       M_AXI_ARID,
  input  logic [1:0]                    M_AXI_ARBURST,
  input  logic [2:0]                    M_AXI_ARSIZE,
  input  logic [7:0]                    M_AXI_ARLEN,
  output logic [AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
  output logic [1:0]                    M_AXI_RRESP,
  output logic                          M_AXI_RVALID,
  output logic [AXI_ID_WIDTH-1:0]       M_AXI_RID,
  output logic                          M_AXI_RLAST,
  input  logic                          M_AXI_RREADY,
  output logic [31:0]                   hit_count,
  output logic [31:0]                   miss_count
);
  localparam int WI  = $clog2(MEM_WORDS);
  localparam int CI  = $clog2(CACHE_LINES);
  localparam int NB  = AXI_DATA_WIDTH / 8;
  localparam int LCW = (MISS_LATENCY > 1) ? $clog2(MISS_LATENCY) : 1;
  localparam logic [LCW-1:0] LAT_LAST = LCW'(MISS_LATENCY - 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] WR_DATA   = 3'd1;
  localparam logic [2:0] WR_RESP   = 3'd2;
  localparam logic [2:0] RD_LOOKUP = 3'd3;
  localparam logic [2:0] RD_MISS   = 3'd4;
  localparam logic [2:0] RD_DATA   = 3'd5;

  logic [2:0]                state;
  logic [AXI_ADDR_WIDTH-1:0] addr;
  logic [AXI_ID_WIDTH-1:0]   id;
  logic [7:0]                len, beat;
  logic [1:0]                burst;
  logic                      err, wr_err;
  logic [LCW-1:0]            lat_cnt;
  logic [AXI_DATA_WIDTH-1:0] rdata;

  logic [AXI_DATA_WIDTH-1:0] mem        [MEM_WORDS];
  logic [AXI_DATA_WIDTH-1:0] cache_data [CACHE_LINES];
  logic [WI-CI-1:0]          cache_tag  [CACHE_LINES];
  logic [CACHE_LINES-1:0]    cache_valid;

  logic [WI-1:0]             widx;
  logic [CI-1:0]             cidx;
  logic [WI-CI-1:0]          tag;
  logic                      hit, mem_we, fill, last_beat;
  logic [AXI_ADDR_WIDTH-1:0] next_addr;

  // Upper address bits are ignored so high addresses alias low memory.
  assign widx      = addr[3 +: WI];
  assign cidx      = widx[CI-1:0];
  assign tag       = widx[WI-1:CI];
  assign hit       = cache_valid[cidx] && (cache_tag[cidx] == tag);
  assign last_beat = (beat == len);
  assign next_addr = (burst == 2'b00) ? addr : addr + AXI_ADDR_WIDTH'(8);
  assign mem_we    = (state == WR_DATA) && M_AXI_WVALID && !err;
  assign fill      = (state == RD_MISS) && (lat_cnt == LAT_LAST);

  assign M_AXI_AWREADY = (state == IDLE);
  assign M_AXI_ARREADY = (state == IDLE) && !M_AXI_AWVALID;
  assign M_AXI_WREADY  = (state == WR_DATA);
  assign M_AXI_BVALID  = (state == WR_RESP);
  assign M_AXI_BRESP   = wr_err ? 2'b10 : 2'b00;
  assign M_AXI_BID     = id;
  assign M_AXI_RVALID  = (state == RD_DATA);
  assign M_AXI_RRESP   = (M_AXI_RVALID && err) ? 2'b10 : 2'b00;
  assign M_AXI_RID     = id;
  assign M_AXI_RLAST   = M_AXI_RVALID && last_beat;
  assign M_AXI_RDATA   = rdata;

  always_ff @(posedge clk) begin
    if (mem_we)
      for (int b = 0; b < NB; b++)
        if (M_AXI_WSTRB[b]) mem[widx][8*b +: 8] <= M_AXI_WDATA[8*b +: 8];
  end

  // Write hits merge into the line; misses never allocate.
  always_ff @(posedge clk) begin
    if (mem_we && hit)
      for (int b = 0; b < NB; b++)
        if (M_AXI_WSTRB[b]) cache_data[cidx][8*b +: 8] <= M_AXI_WDATA[8*b +: 8];
    if (fill) begin
      cache_tag[cidx]  <= tag;
      cache_data[cidx] <= mem[widx];
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state       <= IDLE;
      addr        <= '0;
      id          <= '0;
      len         <= '0;
      beat        <= '0;
      burst       <= '0;
      err         <= 1'b0;
      wr_err      <= 1'b0;
      lat_cnt     <= '0;
      rdata       <= '0;
      hit_count   <= '0;
      miss_count  <= '0;
      cache_valid <= '0;
    end else begin
      case (state)
        IDLE: begin
          beat <= '0;
          if (M_AXI_AWVALID) begin
            addr   <= M_AXI_AWADDR;
            id     <= M_AXI_AWID;
            len    <= M_AXI_AWLEN;
            burst  <= M_AXI_AWBURST;
            err    <= (M_AXI_AWBURST == 2'b10) || (M_AXI_AWSIZE != 3'd3);
            wr_err <= (M_AXI_AWBURST == 2'b10) || (M_AXI_AWSIZE != 3'd3);
            state  <= WR_DATA;
          end else if (M_AXI_ARVALID) begin
            addr   <= M_AXI_ARADDR;
            id     <= M_AXI_ARID;
            len    <= M_AXI_ARLEN;
            burst  <= M_AXI_ARBURST;
            err    <= (M_AXI_ARBURST == 2'b10) || (M_AXI_ARSIZE != 3'd3);
            state  <= RD_LOOKUP;
          end
        end
        WR_DATA: if (M_AXI_WVALID) begin
          if (M_AXI_WLAST != last_beat) wr_err <= 1'b1;
          if (last_beat) state <= WR_RESP;
          else begin
            beat <= beat + 8'd1;
            addr <= next_addr;
          end
        end
        WR_RESP: if (M_AXI_BREADY) state <= IDLE;
        RD_LOOKUP: begin
          if (err) begin
            rdata <= '0;
            state <= RD_DATA;
          end else if (hit) begin
            rdata     <= cache_data[cidx];
            hit_count <= hit_count + 32'd1;
            state     <= RD_DATA;
          end else begin
            miss_count <= miss_count + 32'd1;
            lat_cnt    <= '0;
            state      <= RD_MISS;
          end
        end
        RD_MISS: begin
          if (fill) begin
            cache_valid[cidx] <= 1'b1;
            rdata             <= mem[widx];
            state             <= RD_DATA;
          end else lat_cnt <= lat_cnt + LCW'(1);
        end
        RD_DATA: if (M_AXI_RREADY) begin
          if (last_beat) state <= IDLE;
          else begin
            beat  <= beat + 8'd1;
            addr  <= next_addr;
            state <= RD_LOOKUP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_mm_cache_slave.sv
// Directed bench for axi_mm_cache_slave: a word-level memory/cache-tag model
// predicts every R and B beat; literal expectations pin the model itself.
module tb_axi_mm_cache_slave;
  localparam int MEM_WORDS = 1024;
  localparam int CL        = 16;
  localparam int ML        = 4;
  localparam int LIM       = 200;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] M_AXI_AWADDR = '0;
  logic        M_AXI_AWVALID = 1'b0;
  logic        M_AXI_AWREADY;
  logic [3:0]  M_AXI_AWID = '0;
  logic [1:0]  M_AXI_AWBURST = '0;
  logic [2:0]  M_AXI_AWSIZE = '0;
  logic [7:0]  M_AXI_AWLEN = '0;
  logic [63:0] M_AXI_WDATA = '0;
  logic [7:0]  M_AXI_WSTRB = '0;
  logic        M_AXI_WVALID = 1'b0;
  logic        M_AXI_WLAST = 1'b0;
  logic        M_AXI_WREADY;
  logic [1:0]  M_AXI_BRESP;
  logic        M_AXI_BVALID;
  logic [3:0]  M_AXI_BID;
  logic        M_AXI_BREADY = 1'b0;
  logic [31:0] M_AXI_ARADDR = '0;
  logic        M_AXI_ARVALID = 1'b0;
  logic        M_AXI_ARREADY;
  logic [3:0]  M_AXI_ARID = '0;
  logic [1:0]  M_AXI_ARBURST = '0;
  logic [2:0]  M_AXI_ARSIZE = '0;
  logic [7:0]  M_AXI_ARLEN = '0;
  logic [63:0] M_AXI_RDATA;
  logic [1:0]  M_AXI_RRESP;
  logic        M_AXI_RVALID;
  logic [3:0]  M_AXI_RID;
  logic        M_AXI_RLAST;
  logic        M_AXI_RREADY = 1'b0;
  logic [31:0] hit_count, miss_count;

  axi_mm_cache_slave #(
    .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(4),
    .MEM_WORDS(MEM_WORDS), .CACHE_LINES(CL), .MISS_LATENCY(ML)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_AWID(M_AXI_AWID), .M_AXI_AWBURST(M_AXI_AWBURST), .M_AXI_AWSIZE(M_AXI_AWSIZE),
    .M_AXI_AWLEN(M_AXI_AWLEN), .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WLAST(M_AXI_WLAST), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BID(M_AXI_BID),
    .M_AXI_BREADY(M_AXI_BREADY), .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARVALID(M_AXI_ARVALID),
    .M_AXI_ARREADY(M_AXI_ARREADY), .M_AXI_ARID(M_AXI_ARID), .M_AXI_ARBURST(M_AXI_ARBURST),
    .M_AXI_ARSIZE(M_AXI_ARSIZE), .M_AXI_ARLEN(M_AXI_ARLEN), .M_AXI_RDATA(M_AXI_RDATA),
    .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RID(M_AXI_RID),
    .M_AXI_RLAST(M_AXI_RLAST), .M_AXI_RREADY(M_AXI_RREADY),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  // Model: flat memory plus line valid/tag bookkeeping (data always comes from memory).
  logic [63:0] mm [MEM_WORDS];
  bit          mv [CL];
  int unsigned mt [CL];
  int unsigned mhit, mmiss;
  typedef struct { logic [63:0] data; logic [1:0] resp; logic [3:0] id; logic last;
                   int unsigned hits; int unsigned misses; } rexp_t;
  typedef struct { logic [3:0] id; logic [1:0] resp; } bexp_t;
  rexp_t rq[$];
  bexp_t bq[$];

  function automatic int unsigned word_of(input logic [31:0] a);
    return (a >> 3) % MEM_WORDS;
  endfunction
  function automatic logic [31:0] step(input logic [31:0] a, input logic [1:0] burst);
    return (burst == 2'b00) ? a : a + 32'd8;
  endfunction

  task automatic model_reset();
    mhit = 0; mmiss = 0;
    for (int i = 0; i < CL; i++) mv[i] = 1'b0;
    rq.delete();
  endtask

  task automatic model_write(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                             input logic [1:0] burst, input logic [2:0] size,
                             input logic [63:0] base, input logic [7:0] strb, input bit bad_last);
    logic [31:0] a = addr;
    bit err = (burst == 2'b10) || (size != 3'd3);
    logic [63:0] d;
    bexp_t e;
    for (int i = 0; i <= int'(len); i++) begin
      d = base + 64'(i);
      if (!err)
        for (int b = 0; b < 8; b++) if (strb[b]) mm[word_of(a)][8*b +: 8] = d[8*b +: 8];
      a = step(a, burst);
    end
    e.id = id;
    e.resp = (err || bad_last) ? 2'b10 : 2'b00;
    bq.push_back(e);
  endtask

  task automatic model_read(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                            input logic [1:0] burst, input logic [2:0] size);
    logic [31:0] a = addr;
    bit err = (burst == 2'b10) || (size != 3'd3);
    int unsigned w;
    rexp_t e;
    for (int i = 0; i <= int'(len); i++) begin
      w = word_of(a);
      e.id = id;
      e.last = (i == int'(len));
      if (err) begin
        e.data = '0; e.resp = 2'b10;
      end else begin
        if (mv[w % CL] && mt[w % CL] == w / CL) mhit++;
        else begin
          mmiss++; mv[w % CL] = 1'b1; mt[w % CL] = w / CL;
        end
        e.data = mm[w]; e.resp = 2'b00;
      end
      e.hits = mhit; e.misses = mmiss;
      rq.push_back(e);
      a = step(a, burst);
    end
  endtask

  // Compare process: every visible R/B beat against the model's head entry.
  always @(negedge clk) begin : cmp
    rexp_t e;
    bexp_t f;
    #1;
    if (M_AXI_RVALID) begin
      if (rq.size() == 0) chk("r_unexpected", 64'(M_AXI_RVALID), 64'(0));
      else begin
        e = rq[0];
        chk("m_rdata", M_AXI_RDATA, e.data);
        chk("m_rresp", 64'(M_AXI_RRESP), 64'(e.resp));
        chk("m_rid", 64'(M_AXI_RID), 64'(e.id));
        chk("m_rlast", 64'(M_AXI_RLAST), 64'(e.last));
        chk("m_hits", 64'(hit_count), 64'(e.hits));
        chk("m_misses", 64'(miss_count), 64'(e.misses));
        if (M_AXI_RREADY) void'(rq.pop_front());
      end
    end
    if (M_AXI_BVALID) begin
      if (bq.size() == 0) chk("b_unexpected", 64'(M_AXI_BVALID), 64'(0));
      else begin
        f = bq[0];
        chk("m_bresp", 64'(M_AXI_BRESP), 64'(f.resp));
        chk("m_bid", 64'(M_AXI_BID), 64'(f.id));
        if (M_AXI_BREADY) void'(bq.pop_front());
      end
    end
  end

  logic [63:0] rd_data [16];
  logic        rd_last [16];
  logic [1:0]  rd_resp [16];
  logic [3:0]  rd_id   [16];

  // All driver tasks start and end just after a falling edge.
  task automatic do_write(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                          input logic [1:0] burst, input logic [2:0] size, input logic [63:0] base,
                          input logic [7:0] strb, input bit bad_last,
                          output logic [1:0] bresp, output logic [3:0] bid);
    int t;
    model_write(addr, id, len, burst, size, base, strb, bad_last);
    M_AXI_AWADDR = addr; M_AXI_AWID = id; M_AXI_AWLEN = len;
    M_AXI_AWBURST = burst; M_AXI_AWSIZE = size; M_AXI_AWVALID = 1'b1;
    M_AXI_WDATA = base; M_AXI_WSTRB = strb; M_AXI_WVALID = 1'b1;
    M_AXI_WLAST = bad_last ? 1'b0 : (len == 8'd0);
    t = 0;
    while (!M_AXI_AWREADY && t < LIM) begin @(negedge clk); t++; end
    if (t >= LIM) chk("aw_timeout", 64'(M_AXI_AWREADY), 64'(1));
    @(negedge clk);
    M_AXI_AWVALID = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      M_AXI_WDATA = base + 64'(i);
      M_AXI_WLAST = bad_last ? 1'b0 : (i == int'(len));
      t = 0;
      while (!M_AXI_WREADY && t < LIM) begin @(negedge clk); t++; end
      if (t >= LIM) chk("w_timeout", 64'(M_AXI_WREADY), 64'(1));
      @(negedge clk);
    end
    M_AXI_WVALID = 1'b0; M_AXI_WLAST = 1'b0;
    t = 0;
    while (!M_AXI_BVALID && t < LIM) begin @(negedge clk); t++; end
    if (t >= LIM) chk("b_timeout", 64'(M_AXI_BVALID), 64'(1));
    bresp = M_AXI_BRESP; bid = M_AXI_BID;
    M_AXI_BREADY = 1'b1;
    @(negedge clk);
    M_AXI_BREADY = 1'b0;
  endtask

  task automatic ar_issue(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                          input logic [1:0] burst, input logic [2:0] size);
    int t;
    model_read(addr, id, len, burst, size);
    M_AXI_ARADDR = addr; M_AXI_ARID = id; M_AXI_ARLEN = len;
    M_AXI_ARBURST = burst; M_AXI_ARSIZE = size; M_AXI_ARVALID = 1'b1;
    #1;
    t = 0;
    while (!M_AXI_ARREADY && t < LIM) begin @(negedge clk); #1; t++; end
    if (t >= LIM) chk("ar_timeout", 64'(M_AXI_ARREADY), 64'(1));
    @(negedge clk);
    M_AXI_ARVALID = 1'b0;
  endtask

  // lat = index (relative to AR handshake edge) of the first edge that samples RVALID high.
  task automatic do_read(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                         input logic [1:0] burst, input logic [2:0] size,
                         input int stall_beat, output int lat);
    int n, t;
    ar_issue(addr, id, len, burst, size);
    n = 0;
    while (!M_AXI_RVALID && n < LIM) begin @(negedge clk); n++; end
    lat = n + 1;
    for (int i = 0; i <= int'(len); i++) begin
      t = 0;
      while (!M_AXI_RVALID && t < LIM) begin @(negedge clk); t++; end
      if (t >= LIM) chk("r_timeout", 64'(M_AXI_RVALID), 64'(1));
      if (i == stall_beat) repeat (3) @(negedge clk);
      rd_data[i] = M_AXI_RDATA; rd_last[i] = M_AXI_RLAST;
      rd_resp[i] = M_AXI_RRESP; rd_id[i] = M_AXI_RID;
      M_AXI_RREADY = 1'b1;
      @(negedge clk);
      M_AXI_RREADY = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : drv
    logic [1:0] br;
    logic [3:0] bi;
    int lat;
    for (int i = 0; i < MEM_WORDS; i++) mm[i] = '0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_awready", 64'(M_AXI_AWREADY), 64'(1));
    chk("rst_arready", 64'(M_AXI_ARREADY), 64'(1));
    chk("rst_wready", 64'(M_AXI_WREADY), 64'(0));
    chk("rst_bvalid", 64'(M_AXI_BVALID), 64'(0));
    chk("rst_rvalid", 64'(M_AXI_RVALID), 64'(0));
    chk("rst_rdata", M_AXI_RDATA, 64'h0);
    chk("rst_hits", 64'(hit_count), 64'(0));
    chk("rst_misses", 64'(miss_count), 64'(0));

    // Write then aliased read: miss path
    do_write(32'h0, 4'd0, 8'd0, 2'b01, 3'd3, 64'h1122334455667788, 8'hFF, 1'b0, br, bi);
    chk("t1_bresp", 64'(br), 64'(0));
    chk("t1_bid", 64'(bi), 64'(0));
    do_read(32'h8000_0000, 4'd0, 8'd0, 2'b01, 3'd3, -1, lat);
    chk("t1_lat", 64'(lat), 64'(2 + ML));
    chk("t1_data", rd_data[0], 64'h1122334455667788);
    chk("t1_rlast", 64'(rd_last[0]), 64'(1));
    chk("t1_misses", 64'(miss_count), 64'(1));

    // Same read again: hit path
    do_read(32'h8000_0000, 4'd3, 8'd0, 2'b01, 3'd3, -1, lat);
    chk("t2_lat", 64'(lat), 64'(2));
    chk("t2_rid", 64'(rd_id[0]), 64'(3));
    chk("t2_hits", 64'(hit_count), 64'(1));

    // Partial-strobe write into a cached line
    do_write(32'h0, 4'd1, 8'd0, 2'b01, 3'd3, 64'hAAAAAAAA_BBBBBBBB, 8'h0F, 1'b0, br, bi);
    do_read(32'h0, 4'd1, 8'd0, 2'b01, 3'd3, -1, lat);
    chk("t3_data", rd_data[0], 64'h11223344_BBBBBBBB);
    chk("t3_lat", 64'(lat), 64'(2));

    // 4-beat INCR burst with a mid-burst stall
    do_write(32'h20, 4'd2, 8'd3, 2'b01, 3'd3, 64'd4, 8'hFF, 1'b0, br, bi);
    do_read(32'h20, 4'd2, 8'd3, 2'b01, 3'd3, 1, lat);
    for (int i = 0; i < 4; i++) begin
      chk("t4_data", rd_data[i], 64'(4 + i));
      chk("t4_rlast", 64'(rd_last[i]), 64'(i == 3));
    end
    chk("t4_misses", 64'(miss_count), 64'(5));

    // Simultaneous AW/AR: write goes first
    M_AXI_ARADDR = 32'h20; M_AXI_ARID = 4'd7; M_AXI_ARLEN = 8'd0;
    M_AXI_ARBURST = 2'b01; M_AXI_ARSIZE = 3'd3; M_AXI_ARVALID = 1'b1;
    do_write(32'h20, 4'd6, 8'd0, 2'b01, 3'd3, 64'h99, 8'hFF, 1'b0, br, bi);
    chk("t5_bid", 64'(bi), 64'(6));
    do_read(32'h20, 4'd7, 8'd0, 2'b01, 3'd3, -1, lat);
    chk("t5_data", rd_data[0], 64'h99);
    chk("t5_hits", 64'(hit_count), 64'(3));

    // WRAP write rejected, memory unchanged
    do_write(32'h0, 4'd4, 8'd1, 2'b10, 3'd3, 64'hDEAD, 8'hFF, 1'b0, br, bi);
    chk("t6_bresp", 64'(br), 64'(2));
    do_read(32'h0, 4'd4, 8'd0, 2'b01, 3'd3, -1, lat);
    chk("t6_data", rd_data[0], 64'h11223344_BBBBBBBB);

    // Missing WLAST: SLVERR but data written
    do_write(32'h40, 4'd8, 8'd1, 2'b01, 3'd3, 64'h40, 8'hFF, 1'b1, br, bi);
    chk("t7_bresp", 64'(br), 64'(2));
    do_read(32'h40, 4'd8, 8'd1, 2'b01, 3'd3, -1, lat);
    chk("t7_data0", rd_data[0], 64'h40);
    chk("t7_data1", rd_data[1], 64'h41);
    chk("t7_misses", 64'(miss_count), 64'(7));

    // Bad read size: SLVERR, zero data, counters untouched
    do_read(32'h0, 4'd9, 8'd0, 2'b01, 3'd2, -1, lat);
    chk("t8_rresp", 64'(rd_resp[0]), 64'(2));
    chk("t8_data", rd_data[0], 64'h0);
    chk("t8_hits", 64'(hit_count), 64'(4));

    // FIXED burst: both beats land on one word
    do_write(32'h60, 4'd10, 8'd1, 2'b00, 3'd3, 64'h50, 8'hFF, 1'b0, br, bi);
    do_read(32'h60, 4'd10, 8'd1, 2'b00, 3'd3, -1, lat);
    chk("t9_data0", rd_data[0], 64'h51);
    chk("t9_data1", rd_data[1], 64'h51);
    chk("t9_hits", 64'(hit_count), 64'(5));
    chk("t9_misses", 64'(miss_count), 64'(8));

    // Reset while a miss is being filled
    do_write(32'h100, 4'd5, 8'd0, 2'b01, 3'd3, 64'h77, 8'hFF, 1'b0, br, bi);
    ar_issue(32'h100, 4'd5, 8'd0, 2'b01, 3'd3);
    @(negedge clk);
    @(negedge clk);
    chk("t10_in_miss_rvalid", 64'(M_AXI_RVALID), 64'(0));
    chk("t10_pre_misses", 64'(miss_count), 64'(9));
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    chk("t10_rst_hits", 64'(hit_count), 64'(0));
    chk("t10_rst_misses", 64'(miss_count), 64'(0));
    rst_n = 1'b0;
    repeat (6) @(negedge clk);
    chk("t10_rvalid_idle", 64'(M_AXI_RVALID), 64'(0));
    do_read(32'h100, 4'd5, 8'd0, 2'b01, 3'd3, -1, lat);
    chk("t10_lat", 64'(lat), 64'(2 + ML));
    chk("t10_data", rd_data[0], 64'h77);
    chk("t10_misses", 64'(miss_count), 64'(1));
    do_read(32'h0, 4'd5, 8'd0, 2'b01, 3'd3, -1, lat);
    chk("t10_cold_lat", 64'(lat), 64'(2 + ML));
    chk("t10_cold_data", rd_data[0], 64'h11223344_BBBBBBBB);

    repeat (3) @(negedge clk);
    chk("end_rq_drained", 64'(rq.size()), 64'(0));
    chk("end_bq_drained", 64'(bq.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/axi_mm_cache_slave.md
Name: axi_mm_cache_slave

Overview:
- AXI4 memory-mapped slave: on-chip backing memory fronted by a direct-mapped, write-through, no-write-allocate read cache.
- Sits at the top of the cache subsystem; the upstream AXI master drives the M_AXI_* request channels into it.
- Serves one transaction at a time and exposes hit/miss counters for verification.

Parameters:
- AXI_ADDR_WIDTH, 32, address width.
- AXI_DATA_WIDTH, 64, data width (fixed 64; 8-byte beats).
- AXI_ID_WIDTH, 4, transaction ID width.
- MEM_WORDS, 1024, backing memory depth in 64-bit words (power of 2).
- CACHE_LINES, 16, number of one-word cache lines (power of 2).
- MISS_LATENCY, 4, extra cycles for a read miss fill (>=1).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous reset, active-high (asserted when 1).
- M_AXI_AWADDR  in  AXI_ADDR_WIDTH  write address.
- M_AXI_AWVALID  in  1.
- M_AXI_AWREADY  out  1.
- M_AXI_AWID  in  AXI_ID_WIDTH.
- M_AXI_AWBURST  in  2.
- M_AXI_AWSIZE  in  3.
- M_AXI_AWLEN  in  8.
- M_AXI_WDATA  in  AXI_DATA_WIDTH.
- M_AXI_WSTRB  in  AXI_DATA_WIDTH/8.
- M_AXI_WVALID  in  1.
- M_AXI_WLAST  in  1.
- M_AXI_WREADY  out  1.
- M_AXI_BRESP  out  2.
- M_AXI_BVALID  out  1.
- M_AXI_BID  out  AXI_ID_WIDTH.
- M_AXI_BREADY  in  1.
- M_AXI_ARADDR  in  AXI_ADDR_WIDTH.
- M_AXI_ARVALID  in  1.
- M_AXI_ARREADY  out  1.
- M_AXI_ARID  in  AXI_ID_WIDTH.
- M_AXI_ARBURST  in  2.
- M_AXI_ARSIZE  in  3.
- M_AXI_ARLEN  in  8.
- M_AXI_RDATA  out  AXI_DATA_WIDTH.
- M_AXI_RRESP  out  2.
- M_AXI_RVALID  out  1.
- M_AXI_RID  out  AXI_ID_WIDTH.
- M_AXI_RLAST  out  1.
- M_AXI_RREADY  in  1.
- hit_count  out  32  read hits since reset.
- miss_count  out  32  read misses since reset.

Behaviour:
- Reset: state IDLE; all VALID/READY outputs 0 except as derived from IDLE; RDATA, BRESP, RRESP, BID, RID, counters 0; all cache valid bits cleared. Backing memory is not cleared by reset (zero at power-up). Reset mid-transaction drops it; beats already written stay in memory.
- Word index = addr[3 +: log2(MEM_WORDS)]; upper bits ignored (0x8000_0000 aliases word 0). Cache index = low log2(CACHE_LINES) bits of word index; tag = remaining word-index bits.
- FSM states: IDLE, WR_DATA, WR_RESP, RD_LOOKUP, RD_MISS, RD_DATA.
- IDLE: AWREADY = 1; ARREADY = !AWVALID, so writes win a simultaneous request.
  - AW handshake latches addr, id, len, burst, size -> WR_DATA.
  - AR handshake latches the same fields -> RD_LOOKUP.
- WR_DATA: WREADY = 1. Each beat writes memory bytes selected by WSTRB. On a cache hit, the line is merged with the same strobes; a miss does not allocate.
  - Address: +8 per beat for INCR; held for FIXED.
  - Burst ends on beat number AWLEN -> WR_RESP.
- Write error: WRAP burst or size != 3 gives SLVERR (2'b10); beats are consumed but not written. WLAST not matching the final beat also gives SLVERR; that data is still written.
- WR_RESP: BVALID = 1 with BID and BRESP (OKAY = 0 unless error), held until BREADY, then IDLE.
- RD_LOOKUP: one cycle.
  - Hit: RDATA = line, hit_count++, -> RD_DATA.
  - Miss: -> RD_MISS, miss_count++.
- RD_MISS: wait MISS_LATENCY cycles, fill line (valid, tag, data) from memory, -> RD_DATA.
- RD_DATA: RVALID = 1 with RID, RRESP, and RLAST = (beat == ARLEN); outputs held stable until RREADY.
  - On handshake: last beat -> IDLE; else advance address (INCR/FIXED rule) -> RD_LOOKUP.
  - Read error cases mirror writes: RRESP = SLVERR, RDATA = 0, no cache access, no counter change.
- Latency: AR accepted at edge k; hit gives RVALID from edge k+2; miss gives RVALID from edge k+2+MISS_LATENCY. AW at edge k with WVALID held gives first WREADY beat at edge k+1.
- Counters wrap at 2^32.

Test Plan:
- Write 0x1122334455667788 to 0x0 (LEN 0, size 3, INCR, ID 0, WSTRB 0xFF) -> BVALID, BRESP 0, BID 0; then read 0x80000000 -> miss, RDATA 0x1122334455667788, RLAST 1, RVALID at k+6; miss_count = 1.
- Repeat same read with ID 3 -> hit, RVALID at k+2, RID 3, hit_count = 1.
- Write WSTRB 0x0F, data 0xAAAAAAAA_BBBBBBBB to 0x0 (cached) -> subsequent hit read returns 0x11223344_BBBBBBBB.
- INCR read of 4 beats at 0x20 after writing words 4..7 = 4,5,6,7 -> beats 4,5,6,7, RLAST only on the 4th; RREADY low 3 cycles mid-burst holds RDATA stable.
- Simultaneous AWVALID/ARVALID to the same address -> write completes first; read returns new data.
- WRAP write burst -> BRESP 2'b10, memory unchanged; rst_n pulse during RD_MISS -> RVALID 0, counters 0, next read of the same address misses.
